// File: rtl/frame_accumulator_pkg.sv
// Shared types and defaults for the frame accumulator slice.
// Holds the FSM state enum, default geometry and the beat-counter width helper.
package frame_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_COUNT = 4;

    // Beat counter must be able to hold the value COUNT itself.
    function automatic int cnt_width(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/frame_accumulator_if.sv
// Operand/result handshake bundle for frame_accumulator.
// slave = accumulator side, master = operand source / result consumer side.
interface frame_accumulator_if
    import frame_acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int COUNT = DEF_COUNT
) ();
    localparam int CNT_W = cnt_width(COUNT);

    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_beats;

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_beats
    );

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_beats
    );

endinterface

// File: rtl/frame_accumulator_carry_chain_adder.sv
// WIDTH-bit adder with carry-in/carry-out, built from chained 4-bit nibble slices.
// Widths that are not a multiple of 4 are zero-padded to whole nibbles.
module carry_chain_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    localparam int NIB = (WIDTH + 3) / 4;
    localparam int PW  = NIB * 4;

    logic [NIB:0]  w_c;
    logic [PW-1:0] w_a;
    logic [PW-1:0] w_b;
    logic [PW-1:0] w_s;
    logic [PW:0]   w_full;

    assign w_a    = PW'(i_a);
    assign w_b    = PW'(i_b);
    assign w_c[0] = i_cin;

    for (genvar g = 0; g < NIB; g++) begin : g_nibble
        assign {w_c[g+1], w_s[g*4 +: 4]} = {1'b0, w_a[g*4 +: 4]}
                                         + {1'b0, w_b[g*4 +: 4]}
                                         + {4'b0000, w_c[g]};
    end

    // With zero padding the true carry-out sits at bit WIDTH of the padded result.
    assign w_full = {w_c[NIB], w_s};
    assign o_sum  = w_full[WIDTH-1:0];
    assign o_cout = w_full[WIDTH];

endmodule

// File: rtl/frame_accumulator.sv
// Sums COUNT operands per frame, tracks sticky carry-out, hands one result per frame.
// Optional macro ACC_SATURATE_EN: clamp acc to all-ones after the first carry-out.
//
//   state | meaning
//   ACC   | accepting operands, in_ready=1 unless clear
//   DONE  | result held on out_*, waiting for out_ready
module frame_accumulator
    import frame_acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int COUNT = DEF_COUNT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    frame_accumulator_if.slave   bus
);
    localparam int CNT_W = cnt_width(COUNT);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_beats;

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_accept;
    logic             w_last;

    carry_chain_adder #(.WIDTH(WIDTH)) u_adder (
        .i_a    (r_acc),
        .i_b    (bus.in_data),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

`ifdef ACC_SATURATE_EN
    // Once any carry has occurred the frame stays pinned at all-ones.
    assign w_acc_next = (r_ovf || w_cout) ? {WIDTH{1'b1}} : w_sum;
`else
    assign w_acc_next = w_sum;
`endif

    assign bus.in_ready = (r_state == ACC) && !bus.clear;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_last       = (r_beats == CNT_W'(COUNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_beats <= '0;
        end else if (bus.clear) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_beats <= '0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_next;
                        r_ovf   <= r_ovf | w_cout;
                        r_beats <= r_beats + CNT_W'(1);
                        if (w_last) r_state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ACC;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_beats <= '0;
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

    assign bus.out_valid = (r_state == DONE);
    assign bus.out_sum   = r_acc;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_beats = r_beats;

endmodule

// File: tb/tb_frame_accumulator.sv
// Self-checking bench for frame_accumulator: directed frames plus randomized traffic
// compared each cycle against an integer-sum model of the frame rules.
module tb_frame_accumulator;

    localparam int WIDTH = 8;
    localparam int COUNT = 4;

    logic clk;
    logic rst_n;

    frame_accumulator_if #(.WIDTH(WIDTH), .COUNT(COUNT)) bus ();

    frame_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is just the integer total of its accepted operands.
    bit m_done  = 1'b0;
    int m_total = 0;
    int m_beats = 0;

    function automatic int exp_sum(input int total);
`ifdef ACC_SATURATE_EN
        return (total >= 256) ? 255 : total;
`else
        return total % 256;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_done = 0; m_total = 0; m_beats = 0;
        end else if (bus.clear) begin
            m_done = 0; m_total = 0; m_beats = 0;
        end else if (!m_done) begin
            if (bus.in_valid) begin
                m_total += int'(bus.in_data);
                m_beats++;
                if (m_beats == COUNT) m_done = 1;
            end
        end else if (bus.out_ready) begin
            m_done = 0; m_total = 0; m_beats = 0;
        end
    end

    always @(negedge clk) begin
        check("in_ready", int'(bus.in_ready), int'(!m_done && !bus.clear));
        check("out_valid", int'(bus.out_valid), int'(m_done));
        if (m_done) begin
            check("out_sum", int'(bus.out_sum), exp_sum(m_total));
            check("out_ovf", int'(bus.out_ovf), int'(m_total >= 256));
            check("out_beats", int'(bus.out_beats), COUNT);
        end
    end

    task automatic drive(input bit v, input int d, input bit r, input bit c);
        bus.in_valid  = v;
        bus.in_data   = 8'(d);
        bus.out_ready = r;
        bus.clear     = c;
    endtask

    task automatic step(input bit v, input int d, input bit r, input bit c);
        drive(v, d, r, c);
        @(posedge clk);
        #1;
    endtask

    task automatic frame4(input int a, input int b, input int c, input int d);
        step(1, a, 0, 0);
        step(1, b, 0, 0);
        step(1, c, 0, 0);
        step(1, d, 0, 0);
        drive(0, 0, 0, 0);
    endtask

    task automatic pin_result(input string name, input int sum, input int ovf);
        @(negedge clk);
        check({name, "_valid"}, int'(bus.out_valid), 1);
        check({name, "_sum"}, int'(bus.out_sum), sum);
        check({name, "_ovf"}, int'(bus.out_ovf), ovf);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_sum", int'(bus.out_sum), 0);
        check("rst_out_beats", int'(bus.out_beats), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset in the middle of a frame acts without a clock edge.
        step(1, 'h10, 0, 0);
        step(1, 'h20, 0, 0);
        drive(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_beats", int'(bus.out_beats), 0);
        check("midrst_sum", int'(bus.out_sum), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        frame4(1, 1, 1, 1);
        pin_result("postrst", 'h04, 0);
        step(0, 0, 1, 0);

        // Basic frame, result one cycle after the 4th beat.
        frame4('h11, 'h22, 'h33, 'h44);
        pin_result("basic", 'hAA, 0);
        check("basic_beats", int'(bus.out_beats), 4);
        check("basic_in_ready", int'(bus.in_ready), 0);
        step(0, 0, 1, 0);

        // Wrap / saturate.
        frame4('hFF, 'h01, 'h00, 'h05);
`ifdef ACC_SATURATE_EN
        pin_result("ovf", 'hFF, 1);
`else
        pin_result("ovf", 'h05, 1);
`endif
        step(0, 0, 1, 0);

        // Backpressure with in_valid held high in DONE.
        frame4('h01, 'h02, 'h03, 'h04);
        for (int i = 0; i < 5; i++) step(1, $urandom_range(0, 255), 0, 0);
        pin_result("bp", 'h0A, 0);
        step(0, 0, 1, 0);
        @(negedge clk);
        check("bp_in_ready_after", int'(bus.in_ready), 1);

        // Input stalls: only valid cycles count.
        step(1, 'h01, 0, 0);
        step(0, 'h77, 0, 0);
        step(0, 'h66, 0, 0);
        step(1, 'h02, 0, 0);
        step(1, 'h03, 0, 0);
        step(0, 'h55, 0, 0);
        step(1, 'h04, 0, 0);
        drive(0, 0, 0, 0);
        pin_result("stall", 'h0A, 0);
        step(0, 0, 1, 0);

        // Clear in DONE discards the result even with out_ready high.
        frame4('h10, 'h10, 'h10, 'h10);
        step(0, 0, 1, 1);
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("clr_done_valid", int'(bus.out_valid), 0);

        // Clear alongside a valid beat drops it.
        step(1, 'h07, 0, 0);
        drive(1, 'h50, 0, 1);
        @(negedge clk);
        check("clr_in_ready", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        frame4('h01, 'h02, 'h03, 'h04);
        pin_result("clr_next", 'h0A, 0);
        step(0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 255),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
        end
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
